// File: rtl/beta_ctl_pkg.sv
// Shared types and encodings for the multicycle Beta control unit.
// Latency: none, declarations only.
// Backpressure: not applicable.
package beta_ctl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWR  = 4'd4,
        MEMWB  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11,
        TRAP   = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        FLT_NONE    = 2'd0,
        FLT_OPCODE  = 2'd1,
        FLT_FUNCT   = 2'd2,
        FLT_TIMEOUT = 2'd3
    } fault_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [4:0] ALU_AND = 5'h00;
    localparam logic [4:0] ALU_OR  = 5'h01;
    localparam logic [4:0] ALU_ADD = 5'h02;
    localparam logic [4:0] ALU_SUB = 5'h06;
    localparam logic [4:0] ALU_SLT = 5'h07;
    localparam logic [4:0] ALU_NOR = 5'h0C;

    // States that sit on the memory handshake and count wait cycles.
    function automatic logic waits_on_mem(input state_t s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

// File: rtl/alu_decode.sv
// R-type funct field to ALU operation, with a legality flag.
// Latency: purely combinational.
// Backpressure: none.
module alu_decode
    import beta_ctl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [4:0] alu_op,
    output logic       legal
);

    // Unknown functs report illegal and drive a zero opcode.
    always_comb begin
        alu_op = ALU_AND;
        legal  = 1'b1;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_NOR:  alu_op = ALU_NOR;
            FN_SLT:  alu_op = ALU_SLT;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/ctl_multicycle.sv
// Multicycle Beta control FSM: fetch/decode/execute/memory/writeback with sticky trap.
// Latency: 3..5 cycles per instruction plus one per memory wait cycle.
// Backpressure: holds in FETCH/MEMRD/MEMWR until memReady, traps after MAX_WAIT waits.
module ctl_multicycle
    import beta_ctl_pkg::*;
#(
    parameter int ALUOP_W  = 5,
    parameter int MAX_WAIT = 16,
    parameter int WAIT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opCode,
    input  logic [5:0]         funct,
    input  logic               memReady,
    input  logic               Zero,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               PCEn,
    output logic               IorD,
    output logic               IRWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               MemToReg,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         fault,
    output logic [3:0]         state
);

    state_t            state_q, state_d;
    fault_t            fault_q, fault_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [4:0]        fn_alu_op;
    logic              fn_legal;
    state_t            ready_next;

    alu_decode u_alu_decode (
        .funct  (funct),
        .alu_op (fn_alu_op),
        .legal  (fn_legal)
    );

    // State, fault and wait-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            fault_q <= FLT_NONE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            wait_q  <= wait_d;
        end
    end

    // Next state, fault capture and wait counting.
    always_comb begin
        state_d    = state_q;
        fault_d    = fault_q;
        wait_d     = wait_q;
        ready_next = FETCH;

        case (state_q)
            FETCH:   ready_next = DECODE;
            MEMRD:   ready_next = MEMWB;
            default: ready_next = FETCH;
        endcase

        case (state_q)
            FETCH, MEMRD, MEMWR: begin
                if (memReady) begin
                    state_d = ready_next;
                end else if (wait_q == WAIT_W'(MAX_WAIT)) begin
                    state_d = TRAP;
                    fault_d = FLT_TIMEOUT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            DECODE: begin
                case (opCode)
                    OP_RTYPE:     state_d = EXEC;
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d = TRAP;
                        fault_d = FLT_OPCODE;
                    end
                endcase
            end
            EXEC: begin
                if (fn_legal) begin
                    state_d = RWB;
                end else begin
                    state_d = TRAP;
                    fault_d = FLT_FUNCT;
                end
            end
            MEMADR:  state_d = (opCode == OP_LW) ? MEMRD : MEMWR;
            ADDIEX:  state_d = ADDIWB;
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase

        if (state_d != state_q) begin
            wait_d = '0;
        end
    end

    // Moore control decode; the FETCH strobes also qualify on memReady and reset blanks everything.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        MemToReg    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'd0;
        PCSource    = 2'd0;
        ALUOp       = '0;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'd1;
                    ALUOp   = ALUOP_W'(ALU_ADD);
                    IRWrite = memReady;
                    PCWrite = memReady;
                end
                DECODE: begin
                    ALUSrcB = 2'd3;
                    ALUOp   = ALUOP_W'(ALU_ADD);
                end
                EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALUOP_W'(fn_alu_op);
                end
                RWB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                MEMADR, ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'd2;
                    ALUOp   = ALUOP_W'(ALU_ADD);
                end
                MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                MEMWB: begin
                    MemToReg = 1'b1;
                    RegWrite = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = ALUOP_W'(ALU_SUB);
                    PCWriteCond = 1'b1;
                    PCSource    = 2'd1;
                end
                ADDIWB: RegWrite = 1'b1;
                JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'd2;
                end
                default: ;
            endcase
        end
    end

    assign PCEn  = PCWrite | (PCWriteCond & Zero);
    assign state = reset ? 4'(FETCH) : 4'(state_q);
    assign fault = reset ? 2'(FLT_NONE) : 2'(fault_q);

endmodule

// File: doc/ctl_multicycle.md
Name: ctl_multicycle

Overview:
Multicycle control unit for the Beta datapath; it is the sequential successor to the single-cycle ctl decoder. It steps each instruction through the Fetch/Decode/Execute/Memory/Writeback states and holds on a ready/valid-style memory handshake. Wait cycles are bounded by a parameter, and illegal instructions and memory timeouts enter a sticky trap. It drives the shared-memory, IR, PC and register-file enables of the multicycle datapath.

Parameters:
ALUOP_W, 5, width of ALUOp output
MAX_WAIT, 16, memory wait cycles tolerated per access before timeout trap (1..255)
WAIT_W, 8, width of internal wait counter; must satisfy 2^WAIT_W > MAX_WAIT

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
opCode  in  6  IR[31:26], valid from DECODE onward
funct  in  6  IR[5:0], valid from DECODE onward
memReady  in  1  memory completes the current access this cycle
Zero  in  1  ALU zero flag, used in BRANCH
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load qualified by Zero (internally ANDed; PCEn out)
PCEn  out  1  PCWrite | (PCWriteCond & Zero)
IorD  out  1  0=PC addresses memory, 1=ALUOut
IRWrite  out  1  load IR
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
RegDst  out  1  1=rd, 0=rt
RegWrite  out  1  register file write
MemToReg  out  1  1=MDR, 0=ALUOut
ALUSrcA  out  1  0=PC, 1=regA
ALUSrcB  out  2  0=regB, 1=const 4, 2=signext imm, 3=signext imm<<2
PCSource  out  2  0=ALU, 1=ALUOut, 2=jump target
ALUOp  out  ALUOP_W  ALU operation code
fault  out  2  0=none, 1=illegal opCode, 2=illegal funct, 3=memory timeout
state  out  4  current state encoding (debug)

Behaviour:
- Reset, while asserted: state<=FETCH, waitCnt<=0, fault<=0; every control output is forced to 0 in that cycle. First FETCH outputs appear in the cycle after reset deasserts.
- Moore outputs, decoded from the registered state only. Unlisted outputs are 0 in each state.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=ADD. If memReady: IRWrite=1, PCWrite=1, next DECODE. Otherwise stay in FETCH and increment waitCnt.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=ADD. Dispatch on opCode:
  - 0x00 -> EXEC
  - 0x23 or 0x2B -> MEMADR
  - 0x04 -> BRANCH
  - 0x08 -> ADDIEX
  - 0x02 -> JUMP
  - any other -> TRAP with fault=1
- EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp from funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT. Next RWB. Any other funct -> TRAP with fault=2, and RWB is never entered.
- RWB: RegDst=1, RegWrite=1, MemToReg=0. Next FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=ADD. Next MEMRD for 0x23, MEMWR for 0x2B.
- MEMRD: MemRead=1, IorD=1. Hold until memReady, then MEMWB.
- MEMWR: MemWrite=1, IorD=1. Hold until memReady, then FETCH.
- MEMWB: RegDst=0, MemToReg=1, RegWrite=1. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=SUB, PCWriteCond=1, PCSource=1. Next FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=2, ALUOp=ADD. Next ADDIWB.
- ADDIWB: RegDst=0, MemToReg=0, RegWrite=1. Next FETCH.
- JUMP: PCWrite=1, PCSource=2. Next FETCH.
- ALUOp encodings: AND=0x00, OR=0x01, ADD=0x02, SUB=0x06, SLT=0x07, NOR=0x0C.
- Wait counter:
  - Cleared on every state change.
  - Increments each cycle spent in FETCH, MEMRD or MEMWR without memReady.
  - If waitCnt==MAX_WAIT and memReady=0 -> TRAP with fault=3.
  - memReady in the same cycle as waitCnt==MAX_WAIT completes normally; no trap.
- TRAP: all enables 0. Sticky until reset. fault holds its value; memReady, opCode and funct are ignored.
- Latency with zero wait cycles:
  - R-type 4, LW 5, SW 4, BEQ 3, J 3, ADDI 4.
  - Each wait cycle adds 1.
- Reset mid-instruction: abandons the access and returns to FETCH. A write pulse in flight is dropped the same cycle.
- memReady outside FETCH, MEMRD and MEMWR is ignored.

Decomposition:
- beta_ctl_pkg holds:
  - state_t enum (FETCH, DECODE, MEMADR, MEMRD, MEMWR, MEMWB, EXEC, RWB, BRANCH, ADDIEX, ADDIWB, JUMP, TRAP)
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - funct constants
  - ALUOp constants
  - fault_t enum
- One combinational sub-module, alu_decode: funct -> {ALUOp, legal}. It is reused by EXEC; the FSM plus its output decode stays in ctl_multicycle.

Test Plan:
- Reset for 2 cycles, then release with memReady=1 -> cycle after release: state=FETCH, MemRead=1, IRWrite=1, PCEn=1; all outputs 0 while reset=1.
- R-type add (opCode=0x00, funct=0x20), memReady=1 -> FETCH,DECODE,EXEC,RWB. EXEC ALUOp=0x02. RWB RegWrite=1, RegDst=1. Back in FETCH on cycle 5.
- LW (0x23), memReady low 3 cycles in MEMRD -> MEMRD held 4 cycles, MemRead=1, IorD=1. Then MEMWB with MemToReg=1, RegWrite=1. Total 8 cycles.
- BEQ (0x04) twice, Zero=1 then Zero=0 -> PCEn=1 in BRANCH with PCSource=1 for the first; PCEn=0 for the second. ALUOp=0x06 in both.
- Illegal opCode 0x3F -> TRAP after DECODE, fault=1, all enables 0 for 20 cycles. Illegal funct 0x3F with opCode 0x00 -> fault=2, RegWrite never asserted.
- SW (0x2B) with MAX_WAIT=4 and memReady held 0 -> TRAP with fault=3 after 5 MEMWR cycles. Repeat with memReady=1 on the 5th cycle -> no trap, returns to FETCH.
